// File: rtl/multipit_if.sv
// Configuration, interrupt and readback signals of the multi-channel interval timer.
// The timer side uses the slave modport and the controlling side uses the master modport.
interface multipit_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_reload;
    logic              cfg_enable;
    logic              cfg_repeat;
    logic              cfg_div_en;
    logic [DIV_W-1:0]  prescale;
    logic [N_CH-1:0]   irq_mask;
    logic [N_CH-1:0]   irq_clr;
    logic [CH_W-1:0]   rd_ch;
    logic [CNT_W-1:0]  rd_count;
    logic [N_CH-1:0]   running;
    logic [N_CH-1:0]   irq_pulse;
    logic [N_CH-1:0]   irq_status;
    logic              interrupting;

    modport master (
        output cfg_we, cfg_ch, cfg_reload, cfg_enable, cfg_repeat, cfg_div_en,
        output prescale, irq_mask, irq_clr, rd_ch,
        input  rd_count, running, irq_pulse, irq_status, interrupting
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_reload, cfg_enable, cfg_repeat, cfg_div_en,
        input  prescale, irq_mask, irq_clr, rd_ch,
        output rd_count, running, irq_pulse, irq_status, interrupting
    );
endinterface

// File: rtl/multipit.sv
// Multi-channel programmable interval timer: N_CH down-counters sharing one prescaler,
// each with a one-shot/repeat mode, a one-cycle expiry pulse and a sticky status flag.
module multipit #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    multipit_if.slave bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [DIV_W-1:0] presc_cnt;
    logic             tick;

    logic [CNT_W-1:0] count_q  [N_CH];
    logic [CNT_W-1:0] reload_q [N_CH];
    logic [N_CH-1:0]  run_q;
    logic [N_CH-1:0]  rep_q;
    logic [N_CH-1:0]  div_q;
    logic [N_CH-1:0]  pulse_q;
    logic [N_CH-1:0]  status_q;

    logic [N_CH-1:0]  wr_sel;
    logic [N_CH-1:0]  step;
    logic [N_CH-1:0]  expire;
    logic [CNT_W-1:0] rd_val;

    // A prescale lowered below the current count still produces a tick and wraps at once.
    assign tick = (presc_cnt >= bus.prescale);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + DIV_W'(1);
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        wr_sel = '0;
        step   = '0;
        expire = '0;
        for (int c = 0; c < N_CH; c++) begin
            wr_sel[c] = bus.cfg_we && (bus.cfg_ch == CH_W'(c));
            step[c]   = run_q[c] && (!div_q[c] || tick);
            // A write in the same cycle cancels the expiry entirely.
            expire[c] = step[c] && (count_q[c] == CNT_W'(1)) && !wr_sel[c];
        end
    end

    // NOTE: the counter and reload arrays are small register files and are reset explicitly,
    // because readback must show 0 right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                count_q[c]  <= '0;
                reload_q[c] <= '0;
            end
            run_q    <= '0;
            rep_q    <= '0;
            div_q    <= '0;
            pulse_q  <= '0;
            status_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (wr_sel[c]) begin
                    count_q[c]  <= bus.cfg_reload;
                    reload_q[c] <= bus.cfg_reload;
                    rep_q[c]    <= bus.cfg_repeat;
                    div_q[c]    <= bus.cfg_div_en;
                    run_q[c]    <= bus.cfg_enable && (bus.cfg_reload != '0);
                end else if (expire[c]) begin
                    if (rep_q[c]) begin
                        count_q[c] <= reload_q[c];
                    end else begin
                        count_q[c] <= '0;
                        run_q[c]   <= 1'b0;
                    end
                end else if (step[c]) begin
                    count_q[c] <= count_q[c] - CNT_W'(1);
                end
            end
            pulse_q  <= expire;
            // Set has priority over a same-cycle write-1-to-clear.
            status_q <= (status_q & ~bus.irq_clr) | expire;
        end
    end

    // Out-of-range channel indices match no entry and read back as 0.
    always_comb begin
        rd_val = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (bus.rd_ch == CH_W'(c)) begin
                rd_val = count_q[c];
            end
        end
    end

    assign bus.rd_count     = rd_val;
    assign bus.running      = run_q;
    assign bus.irq_pulse    = pulse_q;
    assign bus.irq_status   = status_q;
    assign bus.interrupting = |(status_q & bus.irq_mask);
endmodule

// File: tb/tb_multipit.sv
// Self-checking bench for multipit with three channels, so that index 3 is out of range.
// A rule-level reference model predicts every output after every clock edge.
module tb_multipit;
    localparam int NC = 3;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    // Reference model state, in plain integers.
    int          m_cnt [NC];
    int          m_rel [NC];
    bit          m_run [NC];
    bit          m_rep [NC];
    bit          m_div [NC];
    logic [NC-1:0] m_pulse;
    logic [NC-1:0] m_stat;
    int          m_presc;

    multipit_if #(.N_CH(NC), .CNT_W(16), .DIV_W(8)) bus ();

    multipit #(.N_CH(NC), .CNT_W(16), .DIV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_cnt[c] = 0;
            m_rel[c] = 0;
            m_run[c] = 0;
            m_rep[c] = 0;
            m_div[c] = 0;
        end
        m_pulse = '0;
        m_stat  = '0;
        m_presc = 0;
    endtask

    // Applies the timer rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit            tk;
        logic [NC-1:0] set;
        tk  = (m_presc >= int'(bus.prescale));
        m_presc = tk ? 0 : m_presc + 1;
        set = '0;
        for (int c = 0; c < NC; c++) begin
            if (bus.cfg_we && int'(bus.cfg_ch) == c) begin
                m_cnt[c] = int'(bus.cfg_reload);
                m_rel[c] = int'(bus.cfg_reload);
                m_run[c] = bus.cfg_enable && (bus.cfg_reload != 0);
                m_rep[c] = bus.cfg_repeat;
                m_div[c] = bus.cfg_div_en;
            end else if (m_run[c] && (!m_div[c] || tk)) begin
                if (m_cnt[c] > 1) begin
                    m_cnt[c] = m_cnt[c] - 1;
                end else begin
                    set[c] = 1'b1;
                    if (m_rep[c]) begin
                        m_cnt[c] = m_rel[c];
                    end else begin
                        m_cnt[c] = 0;
                        m_run[c] = 0;
                    end
                end
            end
        end
        m_pulse = set;
        m_stat  = (m_stat & ~bus.irq_clr) | set;
    endtask

    task automatic compare_all();
        logic [NC-1:0] rv;
        int            r;
        int            exp_rd;
        r      = int'(bus.rd_ch);
        exp_rd = (r < NC) ? m_cnt[r] : 0;
        for (int c = 0; c < NC; c++) rv[c] = m_run[c];
        check("rd_count", 32'(bus.rd_count), exp_rd);
        check("running", 32'(bus.running), 32'(rv));
        check("irq_pulse", 32'(bus.irq_pulse), 32'(m_pulse));
        check("irq_status", 32'(bus.irq_status), 32'(m_stat));
        check("interrupting", 32'(bus.interrupting), 32'(|(m_stat & bus.irq_mask)));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive_cfg(input int ch, input int rel, input bit en, input bit rep, input bit dv);
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = 2'(ch);
        bus.cfg_reload = 16'(rel);
        bus.cfg_enable = en;
        bus.cfg_repeat = rep;
        bus.cfg_div_en = dv;
    endtask

    task automatic write_cfg(input int ch, input int rel, input bit en, input bit rep, input bit dv);
        drive_cfg(ch, rel, en, rep, dv);
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_count"}, 32'(bus.rd_count), 0);
        check({tag, "_running"}, 32'(bus.running), 0);
        check({tag, "_irq_pulse"}, 32'(bus.irq_pulse), 0);
        check({tag, "_irq_status"}, 32'(bus.irq_status), 0);
        check({tag, "_interrupting"}, 32'(bus.interrupting), 0);
    endtask

    initial begin
        int first_pulse;
        int n_pulse;

        vectors     = 0;
        miscompares = 0;
        rst_n          = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_reload = '0;
        bus.cfg_enable = 1'b0;
        bus.cfg_repeat = 1'b0;
        bus.cfg_div_en = 1'b0;
        bus.prescale   = '0;
        bus.irq_mask   = '0;
        bus.irq_clr    = '0;
        bus.rd_ch      = '0;
        model_reset();

        // Power-on reset, released just after a rising edge.
        #12;
        check_all_zero("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Channel 0: period 10, repeating, stepping every clock.
        bus.irq_mask = 3'b001;
        bus.rd_ch    = 2'd0;
        write_cfg(0, 10, 1, 1, 0);
        check("ch0_load", 32'(bus.rd_count), 10);
        for (int k = 1; k <= 30; k++) begin
            step();
            check("ch0_pulse", 32'(bus.irq_pulse[0]), 32'((k % 10) == 0));
            check("ch0_count", 32'(bus.rd_count), 32'(10 - (k % 10)));
        end

        // Clear coinciding with the expiry at edge 40, then a clear on its own.
        for (int k = 31; k <= 39; k++) step();
        bus.irq_clr = 3'b001;
        step();
        check("clr_vs_set_pulse", 32'(bus.irq_pulse[0]), 1);
        check("clr_vs_set_status", 32'(bus.irq_status[0]), 1);
        step();
        check("clr_status", 32'(bus.irq_status[0]), 0);
        check("clr_interrupting", 32'(bus.interrupting), 0);
        bus.irq_clr = 3'b000;
        write_cfg(0, 0, 0, 0, 0);

        // Channel 1: one-shot of 3 prescaler ticks, prescale 3.
        bus.prescale = 8'd3;
        bus.irq_mask = 3'b010;
        bus.rd_ch    = 2'd1;
        write_cfg(1, 3, 1, 0, 1);
        first_pulse = -1;
        n_pulse     = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (bus.irq_pulse[1]) begin
                n_pulse++;
                if (first_pulse < 0) first_pulse = k;
            end
        end
        check("ch1_pulse_count", 32'(n_pulse), 1);
        check("ch1_pulse_edge", 32'(first_pulse), 11);
        check("ch1_running", 32'(bus.running[1]), 0);
        check("ch1_count", 32'(bus.rd_count), 0);
        bus.prescale = 8'd0;

        // Channel 2: rewritten on the cycle it would expire.
        bus.rd_ch = 2'd2;
        write_cfg(2, 4, 1, 1, 0);
        for (int k = 1; k <= 3; k++) step();
        write_cfg(2, 5, 1, 1, 0);
        check("ch2_wr_pulse", 32'(bus.irq_pulse[2]), 0);
        check("ch2_wr_status", 32'(bus.irq_status[2]), 0);
        check("ch2_wr_count", 32'(bus.rd_count), 5);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("ch2_reperiod", 32'(bus.irq_pulse[2]), 32'(k == 5));
        end

        // Out-of-range channel index: write ignored, readback 0.
        write_cfg(3, 7, 1, 1, 0);
        check("bad_ch_running", 32'(bus.running), 32'(3'b100));
        bus.rd_ch = 2'd3;
        #1;
        check("bad_ch_rd", 32'(bus.rd_count), 0);

        // Every channel with reload 1 pulses on every edge.
        write_cfg(0, 1, 1, 1, 0);
        write_cfg(1, 1, 1, 1, 0);
        write_cfg(2, 1, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("all_ones", 32'(bus.irq_pulse), 32'(3'b111));
        end

        // Randomized traffic checked against the model every cycle.
        for (int k = 0; k < 400; k++) begin
            bus.cfg_we     = ($urandom % 4) == 0;
            bus.cfg_ch     = 2'($urandom % 4);
            bus.cfg_reload = 16'($urandom % 12);
            bus.cfg_enable = ($urandom % 4) != 0;
            bus.cfg_repeat = 1'($urandom % 2);
            bus.cfg_div_en = 1'($urandom % 2);
            if (($urandom % 16) == 0) bus.prescale = 8'($urandom % 4);
            bus.irq_mask   = 3'($urandom % 8);
            bus.irq_clr    = (($urandom % 4) == 0) ? 3'($urandom % 8) : 3'b000;
            bus.rd_ch      = 2'($urandom % 4);
            step();
        end
        bus.cfg_we  = 1'b0;
        bus.irq_clr = '0;

        // Asynchronous reset in the middle of counting.
        bus.prescale = 8'd0;
        bus.irq_mask = 3'b111;
        bus.rd_ch    = 2'd0;
        write_cfg(0, 20, 1, 1, 0);
        write_cfg(1, 20, 1, 1, 0);
        write_cfg(2, 2, 1, 1, 0);
        for (int k = 0; k < 5; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            check("idle_pulse", 32'(bus.irq_pulse), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
